nibble_serial_adder_ctrl: RTL
=============================

Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that performs WIDTH-bit add/subtract by time-multiplexing one 4-bit ripple add slice over WIDTH/4 clock cycles, least significant nibble first.
- Carry is registered between nibbles.
- Sits between a requesting datapath and the shared 4-bit adder resource.
- Uses a valid/ready handshake on the operand side and on the result side.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 8. NIBBLES = WIDTH/4 is derived.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start_valid  input  1  requester presents an operation.
- start_ready  output  1  block can accept an operation.
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B.
- cin  input  1  carry-in for add. Ignored when op_sub=1.
- op_sub  input  1  0 = A+B+cin, 1 = A-B (A + ~B + 1).
- busy  output  1  high in RUN and HOLD.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  final carry. For subtract, 1 = no borrow (A >= B unsigned).

Behaviour:
- Reset is asynchronous and active-high. On rst:
  - state = IDLE.
  - All internal registers, sum and cout = 0.
  - res_valid = 0, busy = 0, start_ready = 1.
- Reset mid-operation aborts the operation immediately. No res_valid is produced for it.
- State IDLE:
  - start_ready = 1, busy = 0, res_valid = 0.
  - Acceptance occurs on a rising edge with start_valid=1. On that edge:
    - A register <= a_in.
    - B register <= op_sub ? ~b_in : b_in.
    - Carry register <= op_sub ? 1 : cin.
    - Nibble counter <= 0.
    - state <= RUN.
- State RUN:
  - start_ready = 0, busy = 1, res_valid = 0.
  - On each edge, the 4-bit slice adds A[3:0] + B[3:0] + carry.
  - The 4-bit result is shifted into the top of an internal result shift register, which shifts right by 4.
  - A and B shift right by 4. The carry register takes the slice carry-out. The counter increments.
  - The edge that processes nibble NIBBLES-1 does the following:
    - Loads the sum output register with the completed shift register value.
    - Loads the cout register with the final slice carry.
    - Sets state <= HOLD.
  - RUN lasts exactly NIBBLES cycles.
- State HOLD:
  - start_ready = 0, busy = 1, res_valid = 1.
  - sum and cout are stable.
  - On an edge with res_ready=1, state <= IDLE.
- Latency and throughput:
  - res_valid rises after the NIBBLES-th rising edge following the acceptance edge.
  - Minimum spacing between acceptances is NIBBLES+2 cycles.
  - There is no back-to-back acceptance from HOLD.
- Output stability:
  - sum and cout change only on the RUN->HOLD edge or on reset.
  - They keep the last result through IDLE and through the next RUN.
- Inputs sampling:
  - a_in, b_in, cin and op_sub are sampled only on the acceptance edge.
  - start_valid outside IDLE is ignored and causes no state change.
  - res_ready outside HOLD is ignored.
- Arithmetic:
  - The result equals the WIDTH-bit truncation of the exact sum.
  - cout is bit WIDTH of A + B' + c0, where B' is B or ~B and c0 is the initial carry.
  - Overflow wraps without any flag.
- Control signals start_ready, busy and res_valid are decoded purely from state, with no combinational path from inputs.

Test Plan:
- Reset behaviour: assert rst asynchronously (off a clock edge) in each state.
  - Outputs go to 0 at once, start_ready goes to 1, and state is IDLE.
  - Deassert rst, then run A=16'h0001, B=16'h0001 add -> sum=16'h0002, cout=0.
- Basic add, WIDTH=16: A=16'h1234, B=16'h0FFF, cin=0.
  - Expect sum=16'h2233, cout=0.
  - res_valid is first high after the 4th edge post-acceptance.
  - busy is high for RUN (4 cycles) plus HOLD.
- Carry propagation and wrap:
  - A=16'hFFFF, B=16'h0001, cin=0 -> sum=16'h0000, cout=1.
  - A=16'hFFFF, B=16'hFFFF, cin=1 -> sum=16'hFFFF, cout=1.
  - A=16'h000F, B=16'h0001, cin=0 -> sum=16'h0010, cout=0 (inter-nibble carry).
- Subtract:
  - A=16'h0007, B=16'h0005, op_sub=1, cin=1 -> sum=16'h0002, cout=1.
  - A=16'h0005, B=16'h0007, op_sub=1, cin=0 -> sum=16'hFFFE, cout=0. This confirms cin is ignored when op_sub=1.
- Backpressure:
  - Hold res_ready=0 for 10 cycles in HOLD.
  - res_valid=1 and sum/cout remain stable. start_ready=0.
  - A start_valid with new operands is ignored.
  - Raise res_ready -> IDLE after that edge, and start_ready=1 in the following cycle.
- Abort: assert rst after 2 RUN cycles.
  - res_valid is never raised and sum=0.
  - The next operation, A=16'hABCD, B=16'h1111, add, completes with sum=16'hBCDE, cout=0.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Handshake and data bundle between a requester and the nibble-serial adder.
//   start_valid/start_ready : operation offer / accept
//   a_in, b_in, cin, op_sub : operands and opcode, sampled on acceptance
//   busy                    : sequencer occupied (RUN or HOLD)
//   res_valid/res_ready     : result offer / consume
//   sum, cout               : registered result and final carry
// master = requester side, slave = sequencer side.
interface nibble_serial_adder_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
  logic             op_sub;
  logic             busy;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start_valid, a_in, b_in, cin, op_sub, res_ready,
    input  start_ready, busy, res_valid, sum, cout
  );

  modport slave (
    input  start_valid, a_in, b_in, cin, op_sub, res_ready,
    output start_ready, busy, res_valid, sum, cout
  );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial add/subtract sequencer. One 4-bit ripple slice is reused
// over WIDTH/4 cycles, least significant nibble first, with the carry
// registered between nibbles.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - nibble_serial_adder_ctrl_if.slave (operand/result handshakes)
//
// state | meaning
// IDLE  | ready for a new operation, last result held on sum/cout
// RUN   | one nibble processed per cycle, NIBBLES cycles total
// HOLD  | result presented with res_valid until res_ready
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  nibble_serial_adder_ctrl_if.slave  bus
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry;
  logic             cout_reg;
  logic [CW-1:0]    cnt;

  logic [4:0]       slice;
  logic [WIDTH-1:0] shreg_nxt;
  logic             last_nib;

  // Shared 4-bit slice; bit 4 is the nibble carry-out.
  assign slice     = {1'b0, a_reg[3:0]} + {1'b0, b_reg[3:0]} + {4'b0000, carry};
  // Results enter at the top so after NIBBLES shifts nibble 0 sits at the bottom.
  assign shreg_nxt = {slice[3:0], shreg[WIDTH-1:4]};
  assign last_nib  = (cnt == CW'(NIBBLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      shreg    <= '0;
      sum_reg  <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_valid) begin
            a_reg <= bus.a_in;
            // Subtract is A + ~B + 1, so the incoming carry is forced to 1.
            b_reg <= bus.op_sub ? ~bus.b_in : bus.b_in;
            carry <= bus.op_sub | bus.cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_reg <= a_reg >> 4;
          b_reg <= b_reg >> 4;
          carry <= slice[4];
          shreg <= shreg_nxt;
          cnt   <= cnt + CW'(1);
          if (last_nib) begin
            sum_reg  <= shreg_nxt;
            cout_reg <= slice[4];
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (bus.res_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Handshake outputs are pure state decodes.
  assign bus.start_ready = (state == IDLE);
  assign bus.busy        = (state == RUN) || (state == HOLD);
  assign bus.res_valid   = (state == HOLD);
  assign bus.sum         = sum_reg;
  assign bus.cout        = cout_reg;

endmodule
